// File: rtl/spi_pkg.sv
// Shared SPI subsystem definitions: word/address widths used by the SPI
// master, slave, word RAM and the transmit sequencer, plus the sequencer
// state encoding.
package spi_pkg;

  localparam int DATA_W = 24;  // RAM word == SPI frame
  localparam int ADDR_W = 5;   // 32-word RAM

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_LOAD    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// Bus bundle between the transmit sequencer, the word RAM read port and
// the SPI master transmit handshake.
//   ram_rd_en/ram_addr : read strobe/address toward the RAM
//   ram_rdata          : RAM data, valid one cycle after ram_rd_en
//   tx_valid/tx_data   : word offered to the SPI master
//   tx_ready           : master accepts when high with tx_valid
// master modport = sequencer side, slave modport = RAM/SPI master side.
interface spi_tx_sequencer_if
  import spi_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;

  modport master (
    output ram_rd_en, ram_addr, tx_valid, tx_data,
    input  ram_rdata, tx_ready
  );

  modport slave (
    input  ram_rd_en, ram_addr, tx_valid, tx_data,
    output ram_rdata, tx_ready
  );

endinterface

// File: rtl/spi_tx_sequencer.sv
// Transmit sequencer: on start, reads word_cnt consecutive RAM words from
// start_addr (wrapping modulo the RAM depth) and offers each one to the SPI
// master over tx_valid/tx_ready. Pulses done at the end of every run
// (normal, zero-length or aborted).
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : one-cycle command, only honoured in IDLE
//   start_addr : first RAM address, sampled with start
//   word_cnt   : words to send (0..2**ADDR_W), sampled with start
//   abort      : end the run at the next safe point
//   busy, done : run status / end-of-run pulse
//   bus        : RAM read port and master transmit handshake
// Every output is a flop; tx_ready only feeds next-state logic.
module spi_tx_sequencer
  import spi_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW:0]          word_cnt,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  spi_tx_sequencer_if.master   bus
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;     // also drives ram_addr directly
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] txd_q, txd_d;
  logic          txv_q, txv_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;       // sticky abort request

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  // Outputs are computed one cycle ahead so they land in flops together
  // with the state they belong to.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    // abort seen this cycle counts immediately, not one cycle late
    abt_d   = abt_q | (busy_q & abort);

    unique case (state_q)
      S_IDLE: begin
        abt_d = 1'b0;
        if (start) begin
          addr_d = start_addr;
          rem_d  = word_cnt;
          busy_d = 1'b1;
          if (word_cnt == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            rd_d    = 1'b1;
          end
        end
      end

      // Read already issued; data arrives while in LOAD regardless of abort.
      S_READ: state_d = S_LOAD;

      S_LOAD: begin
        if (abt_d) begin
          // in-flight read is dropped, word never presented
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          txd_d   = bus.ram_rdata;
          txv_d   = 1'b1;
          state_d = S_PRESENT;
        end
      end

      // A presented word is never withdrawn; abort only takes effect
      // after its handshake.
      S_PRESENT: begin
        if (bus.tx_ready) begin
          txv_d  = 1'b0;
          addr_d = addr_q + 1'b1;     // wraps at RAM depth
          rem_d  = rem_q - 1'b1;
          if (abt_d || rem_q == {{AW{1'b0}}, 1'b1}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            rd_d    = 1'b1;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        abt_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        txv_d   = 1'b0;
        abt_d   = 1'b0;
      end
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.ram_rd_en = rd_q;
  assign bus.ram_addr  = addr_q;
  assign bus.tx_valid  = txv_q;
  assign bus.tx_data   = txd_q;

endmodule
